// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector: stall, flush and memory freeze control.
// Also keeps saturating stall/flush counters and a sticky memory timeout flag.
module hazard_stall_unit #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             IF_ID_UsesRt,
    input  logic             ID_Branch,
    input  logic             ID_BranchTaken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             Mem_Busy,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Pipe_Freeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FREEZE,
        ERROR
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic          stall_inc;
    logic          flush_inc;
    logic          load_use;
    logic          br_haz;
    logic          hazard;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic srcmatch(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        return (r != 5'd0) &&
               ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    always_comb begin
        load_use = ID_EX_MemRead &&
                   srcmatch(ID_EX_rd, IF_ID_rs,
                            IF_ID_rt, IF_ID_UsesRt);
        br_haz   = ID_Branch &&
                   ((ID_EX_RegWrite &&
                     srcmatch(ID_EX_rd, IF_ID_rs,
                              IF_ID_rt, IF_ID_UsesRt)) ||
                    (EX_MEM_MemRead &&
                     srcmatch(EX_MEM_rd, IF_ID_rs,
                              IF_ID_rt, IF_ID_UsesRt)));
        hazard   = load_use || br_haz;
    end

    always_comb begin
        state_nxt    = state;
        tcnt_nxt     = tcnt;
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        unique case (state)
            IDLE: begin
                ID_EX_Bubble = 1'b1;
                tcnt_nxt     = '0;
                state_nxt    = RUN;
            end
            RUN: begin
                tcnt_nxt = '0;
                if (Mem_Busy) begin
                    Pipe_Freeze = 1'b1;
                    tcnt_nxt    = TW'(1);
                    state_nxt   = FREEZE;
                end else if (hazard) begin
                    // A taken branch waits here until its operands settle.
                    ID_EX_Bubble = 1'b1;
                    stall_inc    = 1'b1;
                end else if (ID_Branch && ID_BranchTaken) begin
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b1;
                    flush_inc   = 1'b1;
                end else begin
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                end
            end
            FREEZE: begin
                Pipe_Freeze = 1'b1;
                if (!Mem_Busy) begin
                    state_nxt = RUN;
                    tcnt_nxt  = '0;
                end else if (tcnt >= TW'(MEM_TIMEOUT)) begin
                    state_nxt = ERROR;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            ERROR: begin
                Pipe_Freeze = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            MemTimeout <= 1'b0;
        end else if (state_nxt == ERROR) begin
            MemTimeout <= 1'b1;
        end
    end

    // Counters stick at all-ones so long runs never alias to small values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_inc && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (flush_inc && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: vector table plus timeout,
// async reset and counter saturation sequences on a small instance.
module tb_hazard_stall_unit;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       IF_ID_UsesRt;
    logic       ID_Branch;
    logic       ID_BranchTaken;
    logic       ID_EX_MemRead;
    logic       ID_EX_RegWrite;
    logic [4:0] ID_EX_rd;
    logic       EX_MEM_MemRead;
    logic [4:0] EX_MEM_rd;
    logic       Mem_Busy;

    logic        a_pcw, a_ifw, a_bub, a_fl, a_frz, a_to;
    logic [15:0] a_sc, a_fc;
    logic        b_pcw, b_ifw, b_bub, b_fl, b_frz, b_to;
    logic [1:0]  b_sc, b_fc;

    always #5 Clk = ~Clk;

    hazard_stall_unit dut_a (
        .Clk(Clk), .Reset_n(Reset_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_UsesRt(IF_ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
        .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
        .Mem_Busy(Mem_Busy),
        .PCWrite(a_pcw), .IF_ID_Write(a_ifw),
        .ID_EX_Bubble(a_bub), .IF_ID_Flush(a_fl),
        .Pipe_Freeze(a_frz), .MemTimeout(a_to),
        .StallCount(a_sc), .FlushCount(a_fc)
    );

    hazard_stall_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .IF_ID_UsesRt(IF_ID_UsesRt),
        .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
        .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
        .Mem_Busy(Mem_Busy),
        .PCWrite(b_pcw), .IF_ID_Write(b_ifw),
        .ID_EX_Bubble(b_bub), .IF_ID_Flush(b_fl),
        .Pipe_Freeze(b_frz), .MemTimeout(b_to),
        .StallCount(b_sc), .FlushCount(b_fc)
    );

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       br;
        logic       tk;
        logic       exmr;
        logic       exrw;
        logic [4:0] exrd;
        logic       mmr;
        logic [4:0] mrd;
        logic       busy;
        logic [4:0] ctl;  // {pcw, ifw, bubble, flush, freeze}
        int         sc;
        int         fc;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];
    vec_t zv;
    vec_t lu;
    vec_t tb_br;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        IF_ID_rs       = v.rs;
        IF_ID_rt       = v.rt;
        IF_ID_UsesRt   = v.ut;
        ID_Branch      = v.br;
        ID_BranchTaken = v.tk;
        ID_EX_MemRead  = v.exmr;
        ID_EX_RegWrite = v.exrw;
        ID_EX_rd       = v.exrd;
        EX_MEM_MemRead = v.mmr;
        EX_MEM_rd      = v.mrd;
        Mem_Busy       = v.busy;
    endtask

    function automatic logic [4:0] a_ctl();
        return {a_pcw, a_ifw, a_bub, a_fl, a_frz};
    endfunction

    function automatic logic [4:0] b_ctl();
        return {b_pcw, b_ifw, b_bub, b_fl, b_frz};
    endfunction

    initial begin
        zv = '{0,0,0,0,0,0,0,0,0,0,0,5'b00000,0,0};
        lu = '{8,0,0,0,0,1,0,8,0,0,0,5'b00000,0,0};
        tb_br = '{0,0,0,1,1,0,0,0,0,0,0,5'b00000,0,0};
        tbl[0]  = '{0,0,0,0,0,0,0,0,0,0,0,5'b00100,0,0};
        tbl[1]  = '{0,0,0,0,0,0,0,0,0,0,0,5'b11000,0,0};
        tbl[2]  = '{8,0,0,0,0,1,0,8,0,0,0,5'b00100,0,0};
        tbl[3]  = '{8,0,0,0,0,0,0,0,1,8,0,5'b11000,1,0};
        tbl[4]  = '{0,0,0,0,0,1,0,0,0,0,0,5'b11000,1,0};
        tbl[5]  = '{1,5,0,0,0,1,0,5,0,0,0,5'b11000,1,0};
        tbl[6]  = '{0,9,1,1,1,1,1,9,0,0,0,5'b00100,1,0};
        tbl[7]  = '{0,9,1,1,1,0,0,0,1,9,0,5'b00100,2,0};
        tbl[8]  = '{0,9,1,1,1,0,0,0,0,9,0,5'b11010,3,0};
        tbl[9]  = '{0,0,0,0,0,0,0,0,0,0,0,5'b11000,3,1};
        tbl[10] = '{12,0,0,1,0,0,1,12,0,0,0,5'b00100,3,1};
        tbl[11] = '{12,0,0,1,0,0,1,13,0,0,0,5'b11000,4,1};
        tbl[12] = '{7,0,0,0,0,0,1,7,0,0,0,5'b11000,4,1};
        tbl[13] = '{7,0,0,0,0,0,0,0,1,7,0,5'b11000,4,1};
        for (int i = 14; i < 19; i++)
            tbl[i] = '{8,0,0,0,0,1,0,8,0,0,1,5'b00001,4,1};
        tbl[19] = '{8,0,0,0,0,1,0,8,0,0,0,5'b00001,4,1};
        tbl[20] = '{8,0,0,0,0,1,0,8,0,0,0,5'b00100,4,1};
        tbl[21] = '{0,0,0,0,0,0,0,0,0,0,0,5'b11000,5,1};

        Reset_n = 1'b0;
        apply(zv);
        #2;
        check("reset ctl", 32'(a_ctl()), 32'(5'b00100));
        check("reset cnt", {a_sc, a_fc}, 32'd0);
        check("reset to", 32'(a_to), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            #2;
            check($sformatf("row%0d ctl", i),
                  32'(a_ctl()), 32'(tbl[i].ctl));
            check($sformatf("row%0d stall", i),
                  32'(a_sc), tbl[i].sc);
            check($sformatf("row%0d flush", i),
                  32'(a_fc), tbl[i].fc);
            check($sformatf("row%0d to", i),
                  32'(a_to), 32'd0);
            @(negedge Clk);
        end

        // Timeout: busy from the first RUN cycle, ERROR after 5 busy cycles.
        Reset_n = 1'b0;
        apply(zv);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        Mem_Busy = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            #2;
            check($sformatf("busy%0d frz", c),
                  32'(b_ctl()), 32'(5'b00001));
            check($sformatf("busy%0d to", c),
                  32'(b_to), 32'd0);
            @(negedge Clk);
        end
        #2;
        check("err to", 32'(b_to), 32'd1);
        check("err ctl", 32'(b_ctl()), 32'(5'b00001));
        check("a no to", 32'(a_to), 32'd0);
        @(negedge Clk);
        Mem_Busy = 1'b0;
        #2;
        check("err sticky", 32'(b_to), 32'd1);
        check("err hold", 32'(b_ctl()), 32'(5'b00001));
        #1;
        Reset_n = 1'b0;
        #1;
        check("arst to", 32'(b_to), 32'd0);
        check("arst ctl", 32'(b_ctl()), 32'(5'b00100));

        // Saturation: five back-to-back load-use stalls, then four flushes.
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        for (int k = 0; k < 5; k++) begin
            apply(lu);
            #2;
            check($sformatf("sat%0d ctl", k),
                  32'(b_ctl()), 32'(5'b00100));
            check($sformatf("sat%0d cnt", k),
                  32'(b_sc), (k > 3) ? 3 : k);
            @(negedge Clk);
        end
        for (int k = 0; k < 4; k++) begin
            apply(tb_br);
            #2;
            check($sformatf("fsat%0d ctl", k),
                  32'(b_ctl()), 32'(5'b11010));
            check($sformatf("fsat%0d cnt", k),
                  32'(b_fc), k);
            @(negedge Clk);
        end
        apply(zv);
        #2;
        check("b stall sat", 32'(b_sc), 32'd3);
        check("b flush sat", 32'(b_fc), 32'd3);
        check("a stall cnt", 32'(a_sc), 32'd5);
        check("a flush cnt", 32'(a_fc), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
